riscv_muldiv_unit: RTL and testbench



---
 rtl/riscv_muldiv_pkg.sv | 28 ++
 rtl/riscv_muldiv_if.sv | 33 +++
 rtl/muldiv_div_iter.sv | 54 +++++
 rtl/riscv_muldiv_unit.sv | 208 ++++++++++++++++++++
 tb/tb_riscv_muldiv_unit.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_muldiv_pkg.sv
// riscv_muldiv_pkg
// Shared definitions for the RISC-V M-extension multiply/divide unit:
//   - funct3 operation codes OP_MUL .. OP_REMU
//   - FSM state encoding (IDLE, CALC, DONE)
//   - iteration counter width helper, $clog2(XLEN)+1
package riscv_muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must hold the value XLEN itself, hence the extra bit.
    function automatic int cnt_width(input int xlen);
        return $clog2(xlen) + 1;
    endfunction

endpackage

// File: rtl/riscv_muldiv_if.sv
// riscv_muldiv_if
// Request/response bundle between the core datapath (master) and the
// multiply/divide unit (slave).
//   req_valid/req_ready/req_op/req_a/req_b/req_tag : request handshake
//   flush                                         : synchronous abort
//   rsp_valid/rsp_ready/rsp_data/rsp_tag          : response handshake
//   busy                                          : unit not idle
interface riscv_muldiv_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic [4:0]      req_tag;
    logic            flush;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic [4:0]      rsp_tag;
    logic            busy;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag, busy
    );
endinterface

// File: rtl/muldiv_div_iter.sv
// muldiv_div_iter
// Radix-2 restoring divider step on unsigned magnitudes. One quotient bit
// is produced per i_step. The next-state quotient/remainder are exported
// combinationally so the parent can register the final, sign-fixed result
// in the same cycle as the last step.
//   i_clk       : clock
//   i_load      : load dividend/divisor, clear partial remainder
//   i_step      : perform one trial subtraction
//   i_dividend  : dividend magnitude
//   i_divisor   : divisor magnitude (non-zero when stepped)
//   o_quo_nxt   : quotient after the current step
//   o_rem_nxt   : partial remainder after the current step
import riscv_muldiv_pkg::*;

module muldiv_div_iter #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_quo_nxt,
    output logic [XLEN-1:0] o_rem_nxt
);

    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvsr;

    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_fits;

    // Quotient register doubles as the dividend shift register: its MSB
    // feeds the remainder while quotient bits enter at the LSB.
    assign w_shift   = {r_rem, r_quo[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_dvsr};
    assign w_fits    = ~w_diff[XLEN];
    assign o_rem_nxt = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign o_quo_nxt = {r_quo[XLEN-2:0], w_fits};

    always_ff @(posedge i_clk) begin
        if (i_load) begin
            r_quo  <= i_dividend;
            r_rem  <= '0;
            r_dvsr <= i_divisor;
        end else if (i_step) begin
            r_quo  <= o_quo_nxt;
            r_rem  <= o_rem_nxt;
        end
    end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit
// Multi-cycle RISC-V M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/
// REM/REMU on XLEN-bit operands. Operands are reduced to magnitudes at
// accept, processed by a radix-2 shift-add multiplier or the restoring
// divider (muldiv_div_iter), and the sign is applied when the result is
// registered on entry to DONE. Divide-by-zero and signed overflow are
// resolved at accept and skip straight to DONE.
//   SYS_clk     : clock
//   SYS_reset_n : asynchronous active-low reset
//   bus         : riscv_muldiv_if slave (request, response, flush, busy)
// Build option: RISCV_MULDIV_FAST_MUL_EN -- multiplies use a single-cycle
// XLEN x XLEN multiplier and complete in one cycle; divides unchanged.
import riscv_muldiv_pkg::*;

module riscv_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic           SYS_clk,
    input  logic           SYS_reset_n,
    riscv_muldiv_if.slave  bus
);

    localparam int              CNT_W   = cnt_width(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] cneg_x(input logic n, input logic [XLEN-1:0] v);
        return n ? ((~v) + XLEN'(1)) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cneg_2x(input logic n, input logic [2*XLEN-1:0] v);
        return n ? ((~v) + (2*XLEN)'(1)) : v;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [4:0]        r_tag;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_prod;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_calc;
    logic              w_last;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_neg;
    logic              w_special;
    logic [XLEN-1:0]   w_special_val;

    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_prod_nxt;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN-1:0]   w_quo_nxt;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_div_res;
    logic [XLEN-1:0]   w_calc_res;

    // Handshake decodes come only from registered state.
    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.rsp_valid = (r_state == ST_DONE);
    assign bus.rsp_data  = r_result;
    assign bus.rsp_tag   = r_tag;

    assign w_accept = bus.req_valid & (r_state == ST_IDLE) & ~bus.flush;
    assign w_calc   = (r_state == ST_CALC);
    assign w_last   = w_calc & (r_cnt == CNT_W'(1));

    // Operand signedness. MUL low half is sign-agnostic, so it runs unsigned.
    always_comb begin
        w_a_signed = 1'b0;
        w_b_signed = 1'b0;
        case (bus.req_op)
            OP_MULH, OP_DIV, OP_REM: begin
                w_a_signed = 1'b1;
                w_b_signed = 1'b1;
            end
            OP_MULHSU: w_a_signed = 1'b1;
            default: ;
        endcase
    end

    assign w_a_neg = w_a_signed & bus.req_a[XLEN-1];
    assign w_b_neg = w_b_signed & bus.req_b[XLEN-1];
    assign w_a_mag = cneg_x(w_a_neg, bus.req_a);
    assign w_b_mag = cneg_x(w_b_neg, bus.req_b);
    // Remainder follows the dividend; quotient and product follow the xor.
    assign w_neg   = (bus.req_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);

`ifdef RISCV_MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     w_fast_a;
    logic signed [XLEN:0]     w_fast_b;
    logic signed [2*XLEN+1:0] w_fast_prod;

    assign w_fast_a    = $signed({w_a_neg, bus.req_a});
    assign w_fast_b    = $signed({w_b_neg, bus.req_b});
    assign w_fast_prod = (2*XLEN+2)'(w_fast_a) * (2*XLEN+2)'(w_fast_b);
`endif

    // Results known at accept: divide-by-zero, signed overflow and, in the
    // fast build, every multiply.
    always_comb begin
        w_special     = 1'b0;
        w_special_val = '0;
        if (bus.req_op[2]) begin
            if (bus.req_b == '0) begin
                w_special     = 1'b1;
                w_special_val = bus.req_op[1] ? bus.req_a : '1;
            end else if (!bus.req_op[0] && (bus.req_a == MIN_NEG) && (bus.req_b == '1)) begin
                w_special     = 1'b1;
                w_special_val = bus.req_op[1] ? '0 : MIN_NEG;
            end
        end
`ifdef RISCV_MULDIV_FAST_MUL_EN
        else begin
            w_special     = 1'b1;
            w_special_val = (bus.req_op == OP_MUL) ? w_fast_prod[XLEN-1:0]
                                                   : w_fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // Shift-add step: multiplier sits in the low half of r_prod and is
    // consumed LSB first while partial sums accumulate in the high half.
    assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_nxt = {w_mul_sum, r_prod[XLEN-1:1]};
    assign w_prod_fix = cneg_2x(r_neg, w_prod_nxt);
    assign w_mul_res  = (r_op == OP_MUL) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];

    muldiv_div_iter #(
        .XLEN (XLEN)
    ) u_div (
        .i_clk      (SYS_clk),
        .i_load     (w_accept),
        .i_step     (w_calc),
        .i_dividend (w_a_mag),
        .i_divisor  (w_b_mag),
        .o_quo_nxt  (w_quo_nxt),
        .o_rem_nxt  (w_rem_nxt)
    );

    assign w_div_res  = cneg_x(r_neg, r_op[1] ? w_rem_nxt : w_quo_nxt);
    assign w_calc_res = r_op[2] ? w_div_res : w_mul_res;

    // ---- FSM state register ----
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---- FSM next state ----
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_special ? ST_DONE : ST_CALC;
            ST_CALC: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: if (bus.rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (bus.flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // ---- Operand capture and multiply iteration ----
    always_ff @(posedge SYS_clk) begin
        if (w_accept) begin
            r_op    <= bus.req_op;
            r_neg   <= w_neg;
            r_mcand <= w_a_mag;
            r_prod  <= {{XLEN{1'b0}}, w_b_mag};
        end else if (w_calc) begin
            r_prod  <= w_prod_nxt;
        end
    end

    // ---- Counter, tag and result registers ----
    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            r_cnt    <= '0;
            r_tag    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_W'(XLEN);
            r_tag <= bus.req_tag;
            if (w_special) begin
                r_result <= w_special_val;
            end
        end else if (w_calc && !bus.flush) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_result <= w_calc_res;
            end
        end
    end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
module tb_riscv_muldiv_unit;

    localparam int          XLEN = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    riscv_muldiv_if #(.XLEN(XLEN)) bus();

    riscv_muldiv_unit #(.XLEN(XLEN)) dut (
        .SYS_clk     (clk),
        .SYS_reset_n (rst_n),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Architectural reference: plain signed/unsigned arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic        [63:0] up;
        case (op)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
            3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
`ifdef RISCV_MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    // Scoreboard/compare process: samples on the falling edge.
    bit          m_have;
    bit          m_seen;
    int          m_lat;
    int          m_exp_lat;
    logic [31:0] m_exp_data;
    logic [4:0]  m_exp_tag;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_have = 1'b0;
        end else begin
            check("busy", {31'b0, bus.busy}, {31'b0, m_have});
            check("req_ready", {31'b0, bus.req_ready}, {31'b0, !m_have});
            if (m_have) begin
                m_lat++;
                if (bus.rsp_valid) begin
                    if (!m_seen) check("latency", m_lat, m_exp_lat);
                    m_seen = 1'b1;
                    check("rsp_data", bus.rsp_data, m_exp_data);
                    check("rsp_tag", {27'b0, bus.rsp_tag}, {27'b0, m_exp_tag});
                end else if (m_seen) begin
                    check("rsp_valid_dropped", 32'd0, 32'd1);
                    m_have = 1'b0;
                end else if (m_lat > m_exp_lat) begin
                    check("rsp_timeout", 32'd0, 32'd1);
                    m_have = 1'b0;
                end
            end else begin
                check("rsp_valid_idle", {31'b0, bus.rsp_valid}, 32'd0);
            end
            // Predict what the coming edge does.
            if (bus.flush) begin
                m_have = 1'b0;
            end else begin
                if (m_have && bus.rsp_valid && bus.rsp_ready) m_have = 1'b0;
                if (!m_have && bus.req_valid) begin
                    m_have     = 1'b1;
                    m_seen     = 1'b0;
                    m_lat      = 0;
                    m_exp_data = ref_result(bus.req_op, bus.req_a, bus.req_b);
                    m_exp_tag  = bus.req_tag;
                    m_exp_lat  = ref_latency(bus.req_op, bus.req_a, bus.req_b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        int n;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("req_ready_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        tick();
        bus.req_valid = 1'b0;
        bus.req_a     = $urandom;
        bus.req_b     = $urandom;
        bus.req_op    = 3'($urandom_range(0, 7));
        bus.req_tag   = 5'($urandom_range(0, 31));
    endtask

    task automatic wait_rsp(input int hold, output logic [31:0] d);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("rsp_wait_timeout", 32'd0, 32'd1);
        repeat (hold) tick();
        d = bus.rsp_data;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input int hold, output logic [31:0] d);
        issue(op, a, b, tag);
        wait_rsp(hold, d);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MINV;
            3: return 32'($urandom_range(1, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tagname);
        check({tagname, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
        check({tagname, "_rsp_data"}, bus.rsp_data, 32'd0);
        check({tagname, "_rsp_tag"}, {27'b0, bus.rsp_tag}, 32'd0);
        check({tagname, "_busy"}, {31'b0, bus.busy}, 32'd0);
        check({tagname, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [31:0] exp_d;
        logic [4:0]  exp_t;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_tag   = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;

        // Model pinned against hand-computed values.
        check("model_mul", ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("model_mulhu", ref_result(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("model_mulhsu", ref_result(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
        check("model_mulh", ref_result(3'd1, MINV, MINV), 32'h4000_0000);
        check("model_div", ref_result(3'd4, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFA);
        check("model_rem", ref_result(3'd6, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFE);

        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Directed cases with literal expectations.
        run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 0, d);        check("mul", d, 32'hFFFF_FFEB);
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1, d); check("mulhu", d, 32'hFFFF_FFFE);
        run(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd2, 0, d);         check("mulhsu", d, 32'hFFFF_FFFF);
        run(3'd1, MINV, MINV, 5'd3, 0, d);                   check("mulh", d, 32'h4000_0000);
        run(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd4, 0, d);         check("div", d, 32'hFFFF_FFFA);
        run(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd5, 0, d);         check("rem", d, 32'hFFFF_FFFE);
        run(3'd5, 32'd100, 32'd7, 5'd6, 0, d);               check("divu", d, 32'd14);
        run(3'd7, 32'd100, 32'd7, 5'd7, 0, d);               check("remu", d, 32'd2);
        run(3'd5, 32'd5, 32'd0, 5'd8, 0, d);                 check("divu_by0", d, 32'hFFFF_FFFF);
        run(3'd6, 32'd5, 32'd0, 5'd10, 0, d);                check("rem_by0", d, 32'd5);
        run(3'd4, MINV, 32'hFFFF_FFFF, 5'd11, 0, d);         check("div_ovf", d, MINV);
        run(3'd6, MINV, 32'hFFFF_FFFF, 5'd12, 0, d);         check("rem_ovf", d, 32'd0);

        // Backpressure with an ignored request pulse while DONE.
        issue(3'd5, 32'd100, 32'd7, 5'd13);
        begin
            int n;
            n = 0;
            while (!bus.rsp_valid && n < 200) begin tick(); n++; end
        end
        exp_d = bus.rsp_data;
        exp_t = bus.rsp_tag;
        check("bp_data_first", exp_d, 32'd14);
        for (int i = 0; i < 5; i++) begin
            check("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
            check("bp_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            if (i == 2) begin
                bus.req_valid = 1'b1;
                bus.req_op    = 3'd0;
                bus.req_a     = 32'd3;
                bus.req_b     = 32'd3;
                bus.req_tag   = 5'd30;
            end
            tick();
            bus.req_valid = 1'b0;
        end
        check("bp_data_held", bus.rsp_data, exp_d);
        check("bp_tag_held", {27'b0, bus.rsp_tag}, 32'd13);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("bp_req_ready_after", {31'b0, bus.req_ready}, 32'd1);

        // Flush a DIV at cycle 10, with a request offered during the flush.
        issue(3'd4, 32'd1000, 32'd7, 5'd14);
        repeat (9) tick();
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        check("flush_req_ready", {31'b0, bus.req_ready}, 32'd1);
        check("flush_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        repeat (40) tick();
        check("flush_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
        run(3'd0, 32'd12, 32'd11, 5'd15, 0, d);              check("mul_after_flush", d, 32'd132);

        // Flush in IDLE with a request present: not accepted.
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        check("flush_idle_busy", {31'b0, bus.busy}, 32'd0);

        // Asynchronous reset mid-CALC.
        issue(3'd7, 32'd12345, 32'd10, 5'd16);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        run(3'd0, 32'hFFFF_FFFF, 32'd5, 5'd17, 0, d);        check("mul_after_rst", d, 32'hFFFF_FFFB);

        // Randomized traffic; the compare process checks every response.
        for (int k = 0; k < 200; k++) begin
            run(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                5'($urandom_range(0, 31)), $urandom_range(0, 3), d);
            if ($urandom_range(0, 3) == 0) tick();
        end
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
